// File: rtl/up_arbiter_pkg.sv
// up_arbiter_pkg: shared types and constants for the UP register-bus arbiter.
//   state_t  - per-channel grant state machine encoding (IDLE / BUSY)
//   TIMER_W  - width of the per-transaction slave-ack timeout counter
package up_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int TIMER_W = 16;

endpackage

// File: rtl/up_arbiter_chan.sv
// up_arbiter_chan: one arbitration channel (read or write) of the UP arbiter.
// Holds the round-robin selector, grant register, IDLE/BUSY state machine and
// the slave-ack timeout counter.
// Ports:
//   clk, rstn   - clock, synchronous active-low reset
//   i_req       - per-port request vector
//   i_m_ack     - ack from the shared slave
//   o_grant     - index of the port currently granted
//   o_m_req     - request forwarded to the slave (granted port's request)
//   o_ack       - per-port ack vector (only the granted bit can be set)
//   o_timeout   - one-cycle pulse when the slave failed to ack in time
//   o_busy      - channel is in BUSY; qualifies the top-level muxes
module up_arbiter_chan
    import up_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int TIMEOUT   = 255,
    localparam int GW       = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic                 i_m_ack,
    output logic [GW-1:0]        o_grant,
    output logic                 o_m_req,
    output logic [NUM_PORTS-1:0] o_ack,
    output logic                 o_timeout,
    output logic                 o_busy
);

    state_t             r_state;
    state_t             w_next;
    logic [GW-1:0]      r_grant;
    logic [GW-1:0]      w_grant;
    logic [GW-1:0]      r_last;
    logic [GW-1:0]      w_last;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timer;
    logic [GW-1:0]      w_sel;
    logic               w_req_g;
    int                 w_best;
    int                 w_dist;

    // Round-robin pick: each requesting port's distance from (last_grant+1)
    // with wrap; the smallest distance wins.
    always_comb begin
        w_sel  = r_last;
        w_best = NUM_PORTS;
        w_dist = 0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_dist = (p + NUM_PORTS - 1 - int'(r_last)) % NUM_PORTS;
            if (i_req[p] && w_dist < w_best) begin
                w_best = w_dist;
                w_sel  = GW'(p);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_last  <= GW'(NUM_PORTS - 1);
            r_timer <= '0;
        end else begin
            r_state <= w_next;
            r_grant <= w_grant;
            r_last  <= w_last;
            r_timer <= w_timer;
        end
    end

    // Every exit from BUSY (ack, abort, timeout) goes through IDLE, so the
    // slave's registered ack can never be seen by the next transaction.
    always_comb begin
        w_next    = r_state;
        w_grant   = r_grant;
        w_last    = r_last;
        w_timer   = r_timer;
        o_m_req   = 1'b0;
        o_ack     = '0;
        o_timeout = 1'b0;
        w_req_g   = i_req[r_grant];
        if (r_state == ST_IDLE) begin
            if (|i_req) begin
                w_next  = ST_BUSY;
                w_grant = w_sel;
                w_timer = '0;
            end
        end else begin
            o_m_req = w_req_g;
            if (!w_req_g) begin
                w_next = ST_IDLE;
                w_last = r_grant;
            end else if (i_m_ack) begin
                o_ack[r_grant] = 1'b1;
                w_next         = ST_IDLE;
                w_last         = r_grant;
            end else if (r_timer == TIMER_W'(TIMEOUT)) begin
                o_ack[r_grant] = 1'b1;
                o_timeout      = 1'b1;
                w_next         = ST_IDLE;
                w_last         = r_grant;
            end else begin
                w_timer = r_timer + 1'b1;
            end
        end
    end

    assign o_grant = r_grant;
    assign o_busy  = (r_state == ST_BUSY);

endmodule

// File: rtl/up_arbiter.sv
// up_arbiter: round-robin sharing of one UP register slave between NUM_PORTS
// requesters; read and write channels are arbitrated independently.
// Ports:
//   clk, rstn                    - clock, synchronous active-low reset
//   s_up_rreq/rack/raddr/rdata   - requester-side read channel (packed per port)
//   s_up_wreq/wack/waddr/wdata   - requester-side write channel (packed per port)
//   m_up_rreq/rack/raddr/rdata   - slave-side read channel
//   m_up_wreq/wack/waddr/wdata   - slave-side write channel
//   rd_timeout / wr_timeout      - one-cycle pulse when the slave never acked
module up_arbiter
    import up_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int BUS_WIDTH     = 4,
    parameter int NUM_PORTS     = 2,
    parameter int TIMEOUT       = 255,
    localparam int DW           = BUS_WIDTH * 8,
    localparam int GW           = $clog2(NUM_PORTS)
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic [NUM_PORTS-1:0]               s_up_rreq,
    output logic [NUM_PORTS-1:0]               s_up_rack,
    input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] s_up_raddr,
    output logic [DW-1:0]                      s_up_rdata,
    input  logic [NUM_PORTS-1:0]               s_up_wreq,
    output logic [NUM_PORTS-1:0]               s_up_wack,
    input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] s_up_waddr,
    input  logic [NUM_PORTS*DW-1:0]            s_up_wdata,
    output logic                               m_up_rreq,
    input  logic                               m_up_rack,
    output logic [ADDRESS_WIDTH-1:0]           m_up_raddr,
    input  logic [DW-1:0]                      m_up_rdata,
    output logic                               m_up_wreq,
    input  logic                               m_up_wack,
    output logic [ADDRESS_WIDTH-1:0]           m_up_waddr,
    output logic [DW-1:0]                      m_up_wdata,
    output logic                               rd_timeout,
    output logic                               wr_timeout
);

    logic [ADDRESS_WIDTH-1:0] w_raddr [NUM_PORTS];
    logic [ADDRESS_WIDTH-1:0] w_waddr [NUM_PORTS];
    logic [DW-1:0]            w_wdata [NUM_PORTS];
    logic [GW-1:0]            w_rgrant;
    logic [GW-1:0]            w_wgrant;
    logic                     w_rbusy;
    logic                     w_wbusy;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
        assign w_raddr[i] = s_up_raddr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign w_waddr[i] = s_up_waddr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign w_wdata[i] = s_up_wdata[i*DW +: DW];
    end

    up_arbiter_chan #(
        .NUM_PORTS (NUM_PORTS),
        .TIMEOUT   (TIMEOUT)
    ) u_rd (
        .clk       (clk),
        .rstn      (rstn),
        .i_req     (s_up_rreq),
        .i_m_ack   (m_up_rack),
        .o_grant   (w_rgrant),
        .o_m_req   (m_up_rreq),
        .o_ack     (s_up_rack),
        .o_timeout (rd_timeout),
        .o_busy    (w_rbusy)
    );

    up_arbiter_chan #(
        .NUM_PORTS (NUM_PORTS),
        .TIMEOUT   (TIMEOUT)
    ) u_wr (
        .clk       (clk),
        .rstn      (rstn),
        .i_req     (s_up_wreq),
        .i_m_ack   (m_up_wack),
        .o_grant   (w_wgrant),
        .o_m_req   (m_up_wreq),
        .o_ack     (s_up_wack),
        .o_timeout (wr_timeout),
        .o_busy    (w_wbusy)
    );

    // Slave-side buses are held at zero while a channel is idle so nothing
    // from an ungranted port leaks onto the shared bus.
    always_comb begin
        m_up_raddr = w_rbusy ? w_raddr[w_rgrant] : '0;
        m_up_waddr = w_wbusy ? w_waddr[w_wgrant] : '0;
        m_up_wdata = w_wbusy ? w_wdata[w_wgrant] : '0;
        s_up_rdata = rd_timeout ? '0 : m_up_rdata;
    end

endmodule

// File: tb/tb_up_arbiter.sv
module tb_up_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int N  = 2;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [N-1:0]    rreq, rack, wreq, wack;
    logic [N*AW-1:0] raddr, waddr;
    logic [N*DW-1:0] wdata;
    logic [DW-1:0]   rdata, m_rdata, m_wdata;
    logic [AW-1:0]   m_raddr, m_waddr;
    logic            m_rreq, m_wreq, m_rack, m_wack, rto, wto;
    logic            slave_en;
    int              nchk = 0;
    int              nbad = 0;

    always #5 clk = ~clk;

    up_arbiter #(
        .ADDRESS_WIDTH (AW),
        .BUS_WIDTH     (4),
        .NUM_PORTS     (N),
        .TIMEOUT       (4)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .s_up_rreq  (rreq),
        .s_up_rack  (rack),
        .s_up_raddr (raddr),
        .s_up_rdata (rdata),
        .s_up_wreq  (wreq),
        .s_up_wack  (wack),
        .s_up_waddr (waddr),
        .s_up_wdata (wdata),
        .m_up_rreq  (m_rreq),
        .m_up_rack  (m_rack),
        .m_up_raddr (m_raddr),
        .m_up_rdata (m_rdata),
        .m_up_wreq  (m_wreq),
        .m_up_wack  (m_wack),
        .m_up_waddr (m_waddr),
        .m_up_wdata (m_wdata),
        .rd_timeout (rto),
        .wr_timeout (wto)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    // Registered slave: acks one cycle after it sees a request.
    initial begin
        logic rq, wq;
        m_rack = 1'b0;
        m_wack = 1'b0;
        forever begin
            @(negedge clk);
            rq = slave_en & m_rreq & ~m_rack;
            wq = slave_en & m_wreq & ~m_wack;
            @(posedge clk);
            #1;
            m_rack = rq;
            m_wack = wq;
        end
    end

    initial begin
        int acks, last_c, tos;
        logic [N-1:0] seen;
        rreq = '0; wreq = '0; m_rdata = '0; slave_en = 1'b1;
        raddr = {32'h004, 32'h000};
        waddr = {32'h004, 32'h000};
        wdata = {32'h22, 32'h11};
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("rst m_rreq", m_rreq, 0);
        chk("rst m_wreq", m_wreq, 0);
        chk("rst acks", {rack, wack}, 0);
        chk("rst m_addr", {m_raddr, m_waddr}, 0);
        chk("rst m_wdata", m_wdata, 0);
        chk("rst timeouts", {rto, wto}, 0);
        chk("rst rdata", rdata, 0);

        // single read, port 1
        nxt; rreq = 2'b10; m_rdata = 32'hA5;
        @(negedge clk); chk("t1 c0 m_rreq", m_rreq, 0);
        nxt; @(negedge clk);
        chk("t1 c1 m_rreq", m_rreq, 1);
        chk("t1 c1 m_raddr", m_raddr, 32'h004);
        chk("t1 c1 rack", rack, 0);
        nxt; @(negedge clk);
        chk("t1 c2 rack", rack, 2'b10);
        chk("t1 c2 rdata", rdata, 32'hA5);
        chk("t1 c2 rto", rto, 0);
        nxt; rreq = 2'b00;
        @(negedge clk);
        chk("t1 c3 m_rreq", m_rreq, 0);
        chk("t1 c3 rack", rack, 0);

        // two writers alternate
        nxt; wreq = 2'b11;
        acks = 0; last_c = 0;
        for (int c = 0; c < 40 && acks < 6; c++) begin
            @(negedge clk);
            seen = wack;
            if (m_wack) begin
                chk("t2 owner", wack, (acks % 2) ? 2'b10 : 2'b01);
                chk("t2 wdata", m_wdata, (acks % 2) ? 32'h22 : 32'h11);
                if (acks > 0) chk("t2 spacing", c - last_c, 3);
                last_c = c;
                acks++;
            end else begin
                chk("t2 no ack", wack, 0);
            end
            nxt; wreq = ~seen;
        end
        wreq = 2'b00;
        chk("t2 ack count", acks, 6);
        nxt;

        // concurrent read port 0 and write port 1
        nxt; rreq = 2'b01; wreq = 2'b10;
        @(negedge clk); chk("t3 c0 reqs", {m_rreq, m_wreq}, 0);
        nxt; @(negedge clk);
        chk("t3 c1 reqs", {m_rreq, m_wreq}, 2'b11);
        chk("t3 c1 m_raddr", m_raddr, 32'h000);
        chk("t3 c1 m_waddr", m_waddr, 32'h004);
        chk("t3 c1 m_wdata", m_wdata, 32'h22);
        nxt; @(negedge clk);
        chk("t3 c2 rack", rack, 2'b01);
        chk("t3 c2 wack", wack, 2'b10);
        nxt; rreq = 2'b00; wreq = 2'b00;
        @(negedge clk); chk("t3 c3 reqs", {m_rreq, m_wreq}, 0);

        // read timeout with TIMEOUT=4; port 1 then port 0
        nxt; slave_en = 1'b0; rreq = 2'b11; m_rdata = 32'hDEADBEEF;
        raddr = {32'h004, 32'h008};
        tos = 0;
        @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
            nxt; @(negedge clk);
            tos += int'(rto);
            if (k < 5) begin
                chk("t4 busy rack", rack, 0);
                chk("t4 busy m_rreq", m_rreq, 1);
                chk("t4 busy m_raddr", m_raddr, 32'h004);
            end else begin
                chk("t4 to rack", rack, 2'b10);
                chk("t4 to rdata", rdata, 0);
                chk("t4 to pulse", rto, 1);
            end
        end
        nxt; rreq = 2'b01; slave_en = 1'b1;
        @(negedge clk);
        tos += int'(rto);
        chk("t4 gap m_rreq", m_rreq, 0);
        chk("t4 gap rack", rack, 0);
        nxt; @(negedge clk);
        tos += int'(rto);
        chk("t4 next m_rreq", m_rreq, 1);
        chk("t4 next m_raddr", m_raddr, 32'h008);
        nxt; @(negedge clk);
        tos += int'(rto);
        chk("t4 next rack", rack, 2'b01);
        chk("t4 next rdata", rdata, 32'hDEADBEEF);
        chk("t4 pulse count", tos, 1);
        nxt; rreq = 2'b00;

        // abort: port 0 drops during BUSY, port 1 pending
        nxt; slave_en = 1'b0; rreq = 2'b01; raddr = {32'h104, 32'h100};
        @(negedge clk);
        nxt; rreq = 2'b11;
        @(negedge clk);
        chk("t5 c1 m_rreq", m_rreq, 1);
        chk("t5 c1 m_raddr", m_raddr, 32'h100);
        nxt; rreq = 2'b10;
        @(negedge clk);
        chk("t5 drop m_rreq", m_rreq, 0);
        chk("t5 drop rack", rack, 0);
        nxt; @(negedge clk);
        chk("t5 gap m_rreq", m_rreq, 0);
        chk("t5 gap rack", rack, 0);
        nxt; @(negedge clk);
        chk("t5 p1 m_rreq", m_rreq, 1);
        chk("t5 p1 m_raddr", m_raddr, 32'h104);

        // reset during BUSY on both channels
        nxt; wreq = 2'b10; waddr = {32'h204, 32'h200}; wdata = {32'h66, 32'h55};
        @(negedge clk);
        nxt; @(negedge clk);
        chk("t6 busy m_wreq", m_wreq, 1);
        chk("t6 busy m_waddr", m_waddr, 32'h204);
        nxt; rstn = 1'b0;
        @(negedge clk);
        chk("t6 sync m_wreq", m_wreq, 1);
        nxt; rstn = 1'b1; rreq = 2'b11; wreq = 2'b11;
        @(negedge clk);
        chk("t6 after m_wreq", m_wreq, 0);
        chk("t6 after m_rreq", m_rreq, 0);
        chk("t6 after acks", {rack, wack}, 0);
        nxt; @(negedge clk);
        chk("t6 regrant m_rreq", m_rreq, 1);
        chk("t6 regrant m_raddr", m_raddr, 32'h100);
        chk("t6 regrant m_wreq", m_wreq, 1);
        chk("t6 regrant m_waddr", m_waddr, 32'h200);
        chk("t6 regrant m_wdata", m_wdata, 32'h55);
        nxt; rreq = 2'b00; wreq = 2'b00;
        nxt;

        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end
endmodule
